// File: rtl/pdm_output_stage_pkg.sv
// Shared definitions for the PDM output stage: soft-mute FSM encoding and dither LFSR constants.
package pdm_output_stage_pkg;

   typedef enum logic [1:0] {
      MUTED     = 2'd0,
      RAMP_UP   = 2'd1,
      RUN       = 2'd2,
      RAMP_DOWN = 2'd3
   } mute_state_t;

   // 16-bit maximal-length Fibonacci LFSR, taps 16,14,13,11
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/pdm_output_stage_sigma_delta_mod1.sv
// First-order sigma-delta modulator: offset-binary u in, registered carry out as 1-bit density.
// Define PDM_OUTPUT_STAGE_DITHER_EN to add -2..+1 LSB of LFSR noise to u (saturated) against idle tones.
module sigma_delta_mod1
   import pdm_output_stage_pkg::*;
#(
   parameter int BITS = 12
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [BITS-1:0] u,
   output logic            pdm_out
);

   logic [BITS:0]   acc;
   logic [BITS-1:0] u_mod;

`ifdef PDM_OUTPUT_STAGE_DITHER_EN
   logic [15:0]            lfsr;
   logic signed [BITS+1:0] u_dith;

   always_ff @(posedge clk) begin
      if (!rst_n) lfsr <= LFSR_SEED;
      else        lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end

   always_comb begin
      u_dith = $signed({2'b00, u}) + (BITS+2)'($signed(lfsr[1:0]));
      u_mod  = u_dith[BITS-1:0];
      if (u_dith[BITS+1])   u_mod = '0;
      else if (u_dith[BITS]) u_mod = '1;
   end
`else
   assign u_mod = u;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) acc <= '0;
      else        acc <= {1'b0, acc[BITS-1:0]} + {1'b0, u_mod};
   end

   assign pdm_out = acc[BITS];

endmodule

// File: rtl/pdm_output_stage.sv
// Final audio stage: one-entry sample buffer, linear interpolation, soft-mute gain ramp, 1-bit sigma-delta out.
// Optional modulator dither is enabled by defining PDM_OUTPUT_STAGE_DITHER_EN.
module pdm_output_stage
   import pdm_output_stage_pkg::*;
#(
   parameter int SAMPLE_BITS  = 12,
   parameter int INTERP_SHIFT = 9,
   parameter int GAIN_BITS    = 8
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   sample_valid,
   input  logic [SAMPLE_BITS-1:0] din,
   output logic                   sample_ready,
   input  logic                   mute,
   output logic                   muted,
   output logic                   underrun,
   output logic                   pdm_out
);

   localparam int DW = SAMPLE_BITS + 1;
   localparam int PW = DW + INTERP_SHIFT + 1;
   localparam int GW = SAMPLE_BITS + GAIN_BITS + 2;
   localparam logic [GAIN_BITS:0] UNITY = {1'b1, {GAIN_BITS{1'b0}}};

   logic                          pending;
   logic signed [SAMPLE_BITS-1:0] held, prev, cur, interp, scaled, scaled_q;
   logic [INTERP_SHIFT-1:0]       phase;
   logic                          boundary, transfer;
   logic [GAIN_BITS:0]            gain, gain_next;
   mute_state_t                   state, state_next;
   logic                          muted_next;
   logic signed [DW-1:0]          diff;
   logic signed [PW-1:0]          prod;
   logic signed [GW-1:0]          gprod;

   assign sample_ready = rst_n && !pending;
   assign transfer     = sample_valid && sample_ready;
   assign boundary     = (phase == '1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending  <= 1'b0;
         held     <= '0;
         prev     <= '0;
         cur      <= '0;
         phase    <= '0;
         underrun <= 1'b0;
      end else begin
         phase <= phase + 1'b1;
         if (boundary) begin
            prev <= cur;
            if (pending) cur <= held;
            else         underrun <= 1'b1;
         end
         // a boundary reads the old held value, so a same-cycle capture cannot clobber it
         if (transfer)      begin held <= din; pending <= 1'b1; end
         else if (boundary) pending <= 1'b0;
      end
   end

   always_comb begin
      diff   = DW'(cur) - DW'(prev);
      prod   = PW'(diff) * $signed(PW'({1'b0, phase}));
      interp = SAMPLE_BITS'(PW'(prev) + (prod >>> INTERP_SHIFT));
      gprod  = GW'(interp) * $signed(GW'({1'b0, gain}));
      scaled = SAMPLE_BITS'(gprod >>> GAIN_BITS);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) scaled_q <= '0;
      else        scaled_q <= scaled;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= MUTED;
         gain  <= '0;
         muted <= 1'b1;
      end else begin
         state <= state_next;
         gain  <= gain_next;
         muted <= muted_next;
      end
   end

   always_comb begin
      state_next = state;
      gain_next  = gain;
      if (boundary) begin
         unique case (state)
            MUTED:   if (!mute) state_next = RAMP_UP;
            RUN:     if (mute)  state_next = RAMP_DOWN;
            default: begin
               // while ramping, each step follows the mute level seen at this boundary
               gain_next = mute ? gain - 1'b1 : gain + 1'b1;
               if (gain_next == '0)         state_next = MUTED;
               else if (gain_next == UNITY) state_next = RUN;
               else                         state_next = mute ? RAMP_DOWN : RAMP_UP;
            end
         endcase
      end
   end

   always_comb muted_next = (state_next == MUTED);

   sigma_delta_mod1 #(.BITS(SAMPLE_BITS)) u_mod (
      .clk     (clk),
      .rst_n   (rst_n),
      .u       ({~scaled_q[SAMPLE_BITS-1], scaled_q[SAMPLE_BITS-2:0]}),
      .pdm_out (pdm_out)
   );

endmodule

// File: tb/tb_pdm_output_stage.sv
// Randomized bench for pdm_output_stage against an arithmetic reference model (short interval for run time).
`timescale 1ns/1ps
module tb_pdm_output_stage;

   localparam int SB    = 12;
   localparam int IS    = 6;
   localparam int GB    = 8;
   localparam int N     = 1 << IS;
   localparam int UNITY = 1 << GB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sample_valid = 1'b0;
   logic [SB-1:0] din = '0;
   logic          mute = 1'b1;
   logic          sample_ready, muted, underrun, pdm_out;

   int ntot = 0;
   int nbad = 0;

   pdm_output_stage #(.SAMPLE_BITS(SB), .INTERP_SHIFT(IS), .GAIN_BITS(GB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .din          (din),
      .sample_ready (sample_ready),
      .mute         (mute),
      .muted        (muted),
      .underrun     (underrun),
      .pdm_out      (pdm_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      ntot++;
      if (obs !== exp) begin
         nbad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int M_MUTED = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3;
   int m_prev, m_cur, m_held, m_phase, m_gain, m_mode, m_scaled, m_acc;
   bit m_pend, m_under, m_muted, m_pdm;

   function automatic int fdiv(input int a, input int sh);
      int d = 1 << sh;
      int q = a / d;
      if (a < 0 && q * d != a) q--;
      return q;
   endfunction

   function automatic int interp_ref(input int p, input int c, input int ph);
      return p + fdiv((c - p) * ph, IS);
   endfunction

   always @(posedge clk) begin : model_step
      int sc;
      bit bnd, xfer;
      if (!rst_n) begin
         m_prev = 0; m_cur = 0; m_held = 0; m_pend = 0; m_phase = 0;
         m_gain = 0; m_mode = M_MUTED; m_under = 0; m_muted = 1;
         m_scaled = 0; m_acc = 0; m_pdm = 0;
      end else begin
         sc    = fdiv(interp_ref(m_prev, m_cur, m_phase) * m_gain, GB);
         m_acc = (m_acc % 4096) + (m_scaled + 2048);
         m_pdm = (m_acc >= 4096);
         m_scaled = sc;
         bnd  = (m_phase == N - 1);
         xfer = sample_valid && !m_pend;
         if (bnd) begin
            m_prev = m_cur;
            if (m_pend) m_cur = m_held;
            else        m_under = 1;
            m_pend = 0;
            case (m_mode)
               M_MUTED: if (!mute) m_mode = M_UP;
               M_RUN:   if (mute)  m_mode = M_DOWN;
               default: begin
                  m_gain = mute ? m_gain - 1 : m_gain + 1;
                  if (m_gain == 0)          m_mode = M_MUTED;
                  else if (m_gain == UNITY) m_mode = M_RUN;
                  else                      m_mode = mute ? M_DOWN : M_UP;
               end
            endcase
         end
         if (xfer) begin
            m_held = int'($signed(din));
            m_pend = 1;
         end
         m_phase = (m_phase + 1) % N;
         m_muted = (m_mode == M_MUTED);
      end
   end

   bit mon_en = 0;
   always @(posedge clk) begin
      if (mon_en) begin
         #1;
         chk("pdm", pdm_out, m_pdm);
         chk("ready", sample_ready, rst_n && !m_pend);
         chk("muted", muted, m_muted);
         chk("underrun", underrun, m_under);
         chk("gain", dut.gain, m_gain);
         chk("cur", dut.cur, m_cur);
         chk("interp", dut.interp, interp_ref(m_prev, m_cur, m_phase));
      end
   end

   // ---------------- sample source ----------------
   int q[$];
   int const_val = 0;
   bit rnd = 0;
   bit feed = 0;
   int max_dly = 4;
   int last_sent = 0;

   initial begin : producer
      forever begin
         @(negedge clk);
         if (feed) begin
            int v;
            int t;
            repeat ($urandom_range(0, max_dly)) @(negedge clk);
            if (q.size() != 0) v = q.pop_front();
            else if (rnd)      v = int'($urandom_range(0, 4095)) - 2048;
            else               v = const_val;
            sample_valid = 1'b1;
            din = SB'(v);
            t = 0;
            while (!sample_ready && t < 4 * N) begin
               @(negedge clk);
               t++;
            end
            chk("send_in_time", (t < 4 * N), 1);
            @(negedge clk);
            sample_valid = 1'b0;
            last_sent = v;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin : main
      int cnt, t, vb;
      repeat (2) @(negedge clk);
      mon_en = 1;
      chk("rst_pdm", pdm_out, 0);
      chk("rst_ready", sample_ready, 0);
      chk("rst_muted", muted, 1);
      chk("rst_underrun", underrun, 0);
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", sample_ready, 1);

      // muted idle: zero signal gives 50% density
      feed = 1; const_val = 0;
      repeat (4 * N) @(negedge clk);
      cnt = 0;
      repeat (4096) begin @(negedge clk); cnt += int'(pdm_out); end
      chk("dens_mute", cnt, 2048);
      chk("muted_idle", muted, 1);

      // ramp up from a boundary-aligned start
      const_val = 2047;
      t = 0;
      while (m_phase != 0 && t < 2 * N) begin @(negedge clk); t++; end
      mute = 1'b0;
      repeat (N) @(negedge clk);
      chk("ramp_start_gain", dut.gain, 0);
      chk("ramp_start_muted", muted, 0);
      repeat (255 * N) @(negedge clk);
      chk("ramp_gain_255", dut.gain, 255);
      repeat (N) @(negedge clk);
      chk("ramp_gain_unity", dut.gain, UNITY);
      chk("run_muted", muted, 0);
      repeat (2 * N) @(negedge clk);
      cnt = 0;
      repeat (4096) begin @(negedge clk); cnt += int'(pdm_out); end
      chk("dens_full", cnt, 4095);

      // interpolation between 0 and 1024
      q.push_back(0); q.push_back(1024); const_val = 1024;
      t = 0;
      while (!(m_prev == 0 && m_cur == 1024 && m_phase == N / 2) && t < 10 * N) begin
         @(negedge clk); t++;
      end
      chk("interp_found", (t < 10 * N), 1);
      chk("interp_mid", dut.interp, 512);
      repeat (N / 2) @(negedge clk);
      chk("interp_bnd", dut.interp, 1024);

      // random samples; valid held across boundaries with a full buffer
      rnd = 1; max_dly = 0;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         while (m_phase != N - 1 && t < 2 * N) begin @(negedge clk); t++; end
         chk("rdy_at_bnd", sample_ready, 0);
         vb = int'($signed(din));
         repeat (N + 1) @(negedge clk);
         chk("no_loss", dut.cur, vb);
      end

      // starve the input
      chk("under_pre", underrun, 0);
      max_dly = 4; feed = 0;
      repeat (4 * N) @(negedge clk);
      chk("underrun_set", underrun, 1);
      chk("ready_idle", sample_ready, 1);
      chk("cur_hold", dut.cur, last_sent);
      feed = 1;
      repeat (3 * N) @(negedge clk);
      chk("underrun_sticky", underrun, 1);

      // reverse a ramp at gain 100
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rnd = 0; const_val = 700; mute = 1'b0; rst_n = 1'b1;
      t = 0;
      while (dut.gain != 100 && t < 120 * N) begin @(negedge clk); t++; end
      chk("reach_100", (t < 120 * N), 1);
      mute = 1'b1;
      for (int k = 99; k >= 0; k--) begin
         repeat (N) @(negedge clk);
         chk("ramp_down", dut.gain, k);
      end
      chk("muted_after_down", muted, 1);

      // reset in the middle of a ramp with underrun set
      mute = 1'b0; feed = 0;
      repeat (4 * N) @(negedge clk);
      chk("under_before_rst", underrun, 1);
      feed = 1;
      repeat (16 * N) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_gain", dut.gain, 0);
      chk("mid_rst_muted", muted, 1);
      chk("mid_rst_under", underrun, 0);
      chk("mid_rst_pdm", pdm_out, 0);
      chk("mid_rst_ready", sample_ready, 0);
      chk("mid_rst_cur", dut.cur, 0);
      chk("mid_rst_prev", dut.prev, 0);
      rst_n = 1'b1;
      repeat (4 * N) @(negedge clk);

      $display("test done: total=%0d bad=%0d", ntot, nbad);
      $finish;
   end

endmodule
